// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle WIDTH x WIDTH multiply sequencer (low half of product).
// Borrows the shared combinational ALU and runs shift-and-add: ADD, SHL, SHR per bit.
// Optional macro: MUL_EARLY_EXIT_EN -- finish as soon as the remaining multiplier is zero.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, op_a, op_b  : request handshake and operands
//   flush                            : synchronous abort back to IDLE
//   res_valid/res_ready, product     : result handshake and low WIDTH bits of op_a*op_b
//   alu_own, alu_a, alu_b, alu_op,
//   alu_sub, alu_ainv, alu_binv,
//   alu_shimm                        : ALU drive (all zero when alu_own is low)
//   alu_res                          : ALU result
module alu_mul_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] product,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_sub,
  output logic             alu_ainv,
  output logic             alu_binv,
  output logic             alu_shimm,
  input  logic [WIDTH-1:0] alu_res
);

  localparam int unsigned CW  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = OPW'(3'b000);
  localparam logic [OPW-1:0] OP_SHL = OPW'(3'b101);
  localparam logic [OPW-1:0] OP_SHR = OPW'(3'b111);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             res_valid_q, res_valid_d;
  logic             last_iter_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Loop termination: fixed count, optionally cut short once the multiplier is exhausted
  always_comb begin
    last_iter_c = (cnt_q == CW'(ITER - 1));
`ifdef MUL_EARLY_EXIT_EN
    if (alu_res == '0) begin
      last_iter_c = 1'b1;
    end
`else
    last_iter_c = last_iter_c;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    if (flush && (state_q != S_IDLE)) begin
      // Abort: datapath holds, product keeps the last completed result
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_ADD;
          end
        end
        S_ADD: begin
          if (mplier_q[0]) begin
            acc_d = alu_res;
          end
          state_d = S_SHL;
        end
        S_SHL: begin
          mcand_d = alu_res;
          state_d = S_SHR;
        end
        S_SHR: begin
          mplier_d = alu_res;
          cnt_d    = CW'(cnt_q + CW'(1));
          if (last_iter_c) begin
            product_d = acc_q;
            state_d   = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    res_valid_d = (state_d == S_DONE);
  end

  // ALU drive and handshake decode from current state
  always_comb begin
    req_ready = (state_q == S_IDLE);
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_sub   = 1'b0;
    alu_ainv  = 1'b0;
    alu_binv  = 1'b0;
    alu_shimm = 1'b0;
    case (state_q)
      S_ADD: begin
        alu_own = 1'b1;
        alu_op  = OP_ADD;
        alu_a   = acc_q;
        alu_b   = mcand_q;
      end
      S_SHL: begin
        alu_own   = 1'b1;
        alu_op    = OP_SHL;
        alu_a     = mcand_q;
        alu_b     = WIDTH'(1);
        alu_shimm = 1'b1;
      end
      S_SHR: begin
        alu_own   = 1'b1;
        alu_op    = OP_SHR;
        alu_a     = mplier_q;
        alu_b     = WIDTH'(1);
        alu_shimm = 1'b1;
      end
      default: ;
    endcase
  end

  assign product   = product_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed testbench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;

  localparam int unsigned W = 16;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_3X5   = 10;
  localparam int LAT_FFFF  = 49;
  localparam int LAT_X7    = 10;
  localparam int LAT_10X10 = 16;
  localparam int LAT_X0    = 4;
`else
  localparam int LAT_3X5   = 49;
  localparam int LAT_FFFF  = 49;
  localparam int LAT_X7    = 49;
  localparam int LAT_10X10 = 49;
  localparam int LAT_X0    = 49;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [W-1:0] op_a, op_b;
  logic         flush;
  logic         res_valid, res_ready;
  logic [W-1:0] product;
  logic         alu_own;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         alu_sub, alu_ainv, alu_binv, alu_shimm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared ALU model: add, shift-left, logical shift-right
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = W'(alu_a + alu_b);
      3'b101:  alu_res = alu_a << alu_b[3:0];
      3'b111:  alu_res = alu_a >> alu_b[3:0];
      default: alu_res = '0;
    endcase
  end

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .product(product),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_sub(alu_sub), .alu_ainv(alu_ainv), .alu_binv(alu_binv), .alu_shimm(alu_shimm),
    .alu_res(alu_res)
  );

  // Run one multiply; check ALU drive, ownership window, latency, product, backpressure, exit
  task automatic run_mul(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_p, input int exp_lat, input int hold);
    int  cyc;
    bit  seen;
    bit  own_bad;
    bit  hold_bad;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_before: got %b expected 1", nm, req_ready);
    end
    req_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0; op_a = '0; op_b = '0;
    cyc = 0; seen = 1'b0; own_bad = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if ({alu_own, alu_op, alu_a, alu_b, alu_sub, alu_ainv, alu_binv, alu_shimm} !==
            {1'b1, 3'b000, 16'h0000, a, 4'b0000}) begin
          errors++; $display("FAIL %s add_drive: got op=%b a=%h b=%h expected op=000 a=0000 b=%h", nm, alu_op, alu_a, alu_b, a);
        end
      end else if (cyc == 2) begin
        checks++;
        if ({alu_op, alu_a, alu_b, alu_shimm} !== {3'b101, a, 16'h0001, 1'b1}) begin
          errors++; $display("FAIL %s shl_drive: got op=%b a=%h b=%h sh=%b expected op=101 a=%h b=0001 sh=1", nm, alu_op, alu_a, alu_b, alu_shimm, a);
        end
      end else if (cyc == 3) begin
        checks++;
        if ({alu_op, alu_a, alu_b, alu_shimm} !== {3'b111, b, 16'h0001, 1'b1}) begin
          errors++; $display("FAIL %s shr_drive: got op=%b a=%h b=%h sh=%b expected op=111 a=%h b=0001 sh=1", nm, alu_op, alu_a, alu_b, alu_shimm, b);
        end
      end
      if (alu_own !== (cyc < exp_lat)) own_bad = 1'b1;
      if (cyc < exp_lat && req_ready !== 1'b0) own_bad = 1'b1;
      if (res_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (own_bad) begin
      errors++; $display("FAIL %s alu_own_window: got bad ownership/req_ready expected own in cycles 1..%0d", nm, exp_lat - 1);
    end
    checks++;
    if (!seen || cyc != exp_lat) begin
      errors++; $display("FAIL %s latency: got cycle %0d (seen=%b) expected %0d", nm, cyc, seen, exp_lat);
    end
    checks++;
    if (product !== exp_p) begin
      errors++; $display("FAIL %s product: got %h expected %h", nm, product, exp_p);
    end
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || product !== exp_p || req_ready !== 1'b0 || alu_own !== 1'b0)
        hold_bad = 1'b1;
    end
    if (hold > 0) begin
      checks++;
      if (hold_bad) begin
        errors++; $display("FAIL %s backpressure: got unstable res_valid/product/req_ready expected stable %h", nm, exp_p);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || product !== exp_p) begin
      errors++; $display("FAIL %s exit_idle: got rr=%b rv=%b p=%h expected rr=1 rv=0 p=%h", nm, req_ready, res_valid, product, exp_p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    #12;
    checks++;
    if ({req_ready, res_valid, product, alu_own, alu_a, alu_b, alu_op, alu_sub, alu_ainv, alu_binv, alu_shimm} !==
        {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 3'b000, 4'b0000}) begin
      errors++; $display("FAIL reset_state: got rr=%b rv=%b p=%h own=%b expected rr=1 rv=0 p=0000 own=0", req_ready, res_valid, product, alu_own);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_mul("basic_3x5", 16'h0003, 16'h0005, 16'h000F, LAT_3X5, 0);
  endtask

  task automatic test_wrap_signed();
    run_mul("wrap_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, LAT_FFFF, 0);
    run_mul("signed_m2x7", 16'hFFFE, 16'h0007, 16'hFFF2, LAT_X7, 0);
  endtask

  task automatic test_backpressure();
    run_mul("bp_3x5", 16'h0003, 16'h0005, 16'h000F, LAT_3X5, 10);
  endtask

  task automatic test_zero_multiplier();
    run_mul("zero_7x0", 16'h0007, 16'h0000, 16'h0000, LAT_X0, 0);
  endtask

  task automatic test_flush();
    bit rv_seen;
    @(negedge clk);
    req_valid = 1'b1; op_a = 16'h1234; op_b = 16'hFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || alu_own !== 1'b0 || res_valid !== 1'b0 || product !== 16'h0000) begin
      errors++; $display("FAIL flush_idle: got rr=%b own=%b rv=%b p=%h expected rr=1 own=0 rv=0 p=0000", req_ready, alu_own, res_valid, product);
    end
    rv_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || alu_own !== 1'b0) rv_seen = 1'b1;
    end
    checks++;
    if (rv_seen) begin
      errors++; $display("FAIL flush_quiet: got activity after flush expected none");
    end
    run_mul("post_flush", 16'h0010, 16'h0010, 16'h0100, LAT_10X10, 0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 1'b1; op_a = 16'h00AA; op_b = 16'h0055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (alu_op !== 3'b101 || alu_own !== 1'b1) begin
      errors++; $display("FAIL pre_reset_shl: got op=%b own=%b expected op=101 own=1", alu_op, alu_own);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, res_valid, product, alu_own, alu_a, alu_b, alu_op, alu_sub, alu_ainv, alu_binv, alu_shimm} !==
        {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 3'b000, 4'b0000}) begin
      errors++; $display("FAIL async_reset: got rr=%b rv=%b p=%h own=%b op=%b expected rr=1 rv=0 p=0000 own=0 op=000", req_ready, res_valid, product, alu_own, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_mul("post_reset", 16'h0003, 16'h0005, 16'h000F, LAT_3X5, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_signed();
    test_backpressure();
    test_zero_multiplier();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
